// File: rtl/msg_ram_pkg.sv
// Shared types and word-format helpers for the message RAM scheduler.
// The optional backspace handling is selected with MSG_BACKSPACE_EN.
package msg_ram_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned CHAR_W    = 8;
  localparam int unsigned PAD_W     = WORD_W - CHAR_W - 1;
  localparam int unsigned VALID_BIT = 15;

  localparam logic [CHAR_W-1:0] BS_CHAR = 8'h08;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    WRITE,
    RD_ADDR,
    RD_WAIT
  } state_t;

  // One stored RAM word: valid flag, zero padding, character
  typedef struct packed {
    logic             valid;
    logic [PAD_W-1:0] pad;
    logic [CHAR_W-1:0] chr;
  } msg_word_t;

  function automatic logic [WORD_W-1:0] pack_word(input logic [CHAR_W-1:0] chr);
    msg_word_t w;
    w.valid = 1'b1;
    w.pad   = '0;
    w.chr   = chr;
    return WORD_W'(w);
  endfunction

endpackage

// File: rtl/msg_ram_clear.sv
// Clear-sweep address counter: walks 0..DEPTH-1 while run is high and
// flags the final address so the scheduler can leave CLEAR.
module msg_ram_clear
  import msg_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              start,
  input  logic              run,
  output logic [ADDR_W-1:0] addr,
  output logic              done_c
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  assign done_c = run && (addr == LAST_ADDR);

  always_ff @(posedge sysclk) begin
    if (reset || start) begin
      addr <= '0;
    end else if (run) begin
      addr <= done_c ? '0 : addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/msg_ram_sched.sv
// Owns the single-port message RAM and arbitrates clear sweep, receiver
// writes and playback reads. Backspace deletion enabled by MSG_BACKSPACE_EN.
module msg_ram_sched
  import msg_ram_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned MAX_CHARS = 160
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              clr_req,
  input  logic              wr_req,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  output logic              wr_drop,
  input  logic              rd_req,
  input  logic              rd_restart,
  output logic              rd_ack,
  output logic [7:0]        rd_data,
  output logic              rd_end,
  output logic [ADDR_W-1:0] count,
  output logic              full,
  output logic              busy,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_din,
  input  logic [15:0]       ram_dout
);

  localparam logic [ADDR_W-1:0] MAX_C = ADDR_W'(MAX_CHARS);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  state_t state, state_d;

  logic [ADDR_W-1:0] rd_ptr, rd_ptr_d;
  logic [ADDR_W-1:0] count_d;
  logic              ram_write_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [15:0]       ram_din_d;
  logic              wr_ack_d, wr_drop_d;
  logic              rd_ack_d, rd_end_d;
  logic [7:0]        rd_data_d;

  logic              clr_start_c, clr_run_c, clr_done_c;
  logic [ADDR_W-1:0] clr_addr;
  logic              is_bs_c;
  logic              unused_dout_c;

`ifdef MSG_BACKSPACE_EN
  assign is_bs_c = (wr_data == BS_CHAR);
`else
  assign is_bs_c = 1'b0;
`endif

  assign unused_dout_c = ^ram_dout[14:8];

  msg_ram_clear #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear (
    .sysclk (sysclk),
    .reset  (reset),
    .start  (clr_start_c),
    .run    (clr_run_c),
    .addr   (clr_addr),
    .done_c (clr_done_c)
  );

  // Next state and next registered outputs
  always_comb begin
    state_d     = state;
    count_d     = count;
    rd_ptr_d    = rd_ptr;
    ram_write_d = 1'b0;
    ram_addr_d  = ram_addr;
    ram_din_d   = ram_din;
    wr_ack_d    = 1'b0;
    wr_drop_d   = 1'b0;
    rd_ack_d    = 1'b0;
    rd_data_d   = rd_data;
    rd_end_d    = rd_end;
    clr_start_c = 1'b0;
    clr_run_c   = 1'b0;

    case (state)
      CLEAR: begin
        clr_run_c   = 1'b1;
        ram_write_d = 1'b1;
        ram_addr_d  = clr_addr;
        ram_din_d   = '0;
        if (clr_done_c) begin
          count_d  = '0;
          rd_ptr_d = '0;
          state_d  = IDLE;
        end
      end

      IDLE: begin
        if (rd_restart) begin
          rd_ptr_d = '0;
        end
        if (clr_req) begin
          clr_start_c = 1'b1;
          state_d     = CLEAR;
        end else if (wr_req) begin
          state_d = WRITE;
        end else if (rd_req) begin
          // Address issued on grant so read data lands in RD_WAIT
          ram_addr_d = rd_ptr_d;
          state_d    = RD_ADDR;
        end
      end

      WRITE: begin
        wr_ack_d = 1'b1;
        state_d  = IDLE;
        if (is_bs_c) begin
          if (count != '0) begin
            ram_write_d = 1'b1;
            ram_addr_d  = count - ONE;
            ram_din_d   = '0;
            count_d     = count - ONE;
            if (rd_ptr > count_d) begin
              rd_ptr_d = count_d;
            end
          end else begin
            wr_drop_d = 1'b1;
          end
        end else if (count < MAX_C) begin
          ram_write_d = 1'b1;
          ram_addr_d  = count;
          ram_din_d   = pack_word(wr_data);
          count_d     = count + ONE;
        end else begin
          wr_drop_d = 1'b1;
        end
      end

      RD_ADDR: begin
        ram_addr_d = rd_ptr;
        state_d    = RD_WAIT;
      end

      RD_WAIT: begin
        rd_ack_d = 1'b1;
        state_d  = IDLE;
        if (ram_dout[VALID_BIT] && (rd_ptr < count)) begin
          rd_data_d = ram_dout[7:0];
          rd_end_d  = 1'b0;
          rd_ptr_d  = rd_ptr + ONE;
        end else begin
          rd_data_d = '0;
          rd_end_d  = 1'b1;
        end
      end

      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= CLEAR;
      count     <= '0;
      rd_ptr    <= '0;
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      wr_ack    <= 1'b0;
      wr_drop   <= 1'b0;
      rd_ack    <= 1'b0;
      rd_data   <= '0;
      rd_end    <= 1'b0;
      full      <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_d;
      count     <= count_d;
      rd_ptr    <= rd_ptr_d;
      ram_write <= ram_write_d;
      ram_addr  <= ram_addr_d;
      ram_din   <= ram_din_d;
      wr_ack    <= wr_ack_d;
      wr_drop   <= wr_drop_d;
      rd_ack    <= rd_ack_d;
      rd_data   <= rd_data_d;
      rd_end    <= rd_end_d;
      full      <= (count_d == MAX_C);
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_msg_ram_sched.sv
// Self-checking bench for msg_ram_sched with a behavioural 256x16 RAM.
// Expectations follow MSG_BACKSPACE_EN when the macro is defined.
module tb_msg_ram_sched;

  localparam int MAX   = 160;
  localparam int LIMIT = 1200;

`ifdef MSG_BACKSPACE_EN
  localparam bit BS = 1'b1;
`else
  localparam bit BS = 1'b0;
`endif

  logic        sysclk = 1'b0;
  logic        reset;
  logic        clr_req, wr_req, rd_req, rd_restart;
  logic [7:0]  wr_data;
  logic        wr_ack, wr_drop, rd_ack, rd_end;
  logic [7:0]  rd_data;
  logic [7:0]  count;
  logic        full, busy, ram_write;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  logic [15:0] mem [256];
  logic        tb_fill;
  logic [7:0]  fill_addr = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic       wr_q [$];
  logic [8:0] rd_q [$];

  typedef struct {
    bit         is_rd;
    bit         restart;
    logic [7:0] data;
    logic       exp_flag;
    logic [7:0] exp_rdata;
    logic [7:0] exp_count;
    int         exp_lat;
  } vec_t;

  vec_t vec [8];

  always #5 sysclk = ~sysclk;

  msg_ram_sched dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .clr_req    (clr_req),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .wr_drop    (wr_drop),
    .rd_req     (rd_req),
    .rd_restart (rd_restart),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .rd_end     (rd_end),
    .count      (count),
    .full       (full),
    .busy       (busy),
    .ram_write  (ram_write),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  // Synchronous single-port RAM, pre-filled with valid-looking junk
  always @(posedge sysclk) begin
    if (tb_fill) begin
      mem[fill_addr] <= 16'hC0DE ^ {8'h00, fill_addr};
      fill_addr      <= fill_addr + 8'd1;
    end else if (ram_write) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: pop an expectation each time the DUT acknowledges
  always @(negedge sysclk) begin
    if (wr_ack === 1'b1) begin
      if (wr_q.size() == 0) check("wr_ack_unexpected", 32'(wr_ack), 32'd0);
      else check("wr_drop", 32'(wr_drop), 32'(wr_q.pop_front()));
    end
    if (rd_ack === 1'b1) begin
      if (rd_q.size() == 0) check("rd_ack_unexpected", 32'(rd_ack), 32'd0);
      else check("rd_end_data", 32'({rd_end, rd_data}), 32'(rd_q.pop_front()));
    end
  end

  task automatic do_write(input logic [7:0] d, input logic exp_drop, output int lat);
    wr_q.push_back(exp_drop);
    wr_data = d;
    wr_req  = 1'b1;
    lat     = 0;
    do begin
      @(negedge sysclk);
      lat++;
    end while (wr_ack !== 1'b1 && lat < LIMIT);
    if (wr_ack !== 1'b1) begin
      check("wr_ack_timeout", 32'(wr_ack), 32'd1);
      void'(wr_q.pop_back());
    end
    wr_req = 1'b0;
  endtask

  task automatic do_read(input bit restart, input logic [7:0] exp_d, input logic exp_e,
                         output int lat);
    rd_q.push_back({exp_e, exp_d});
    rd_restart = restart;
    rd_req     = 1'b1;
    lat        = 0;
    do begin
      @(negedge sysclk);
      rd_restart = 1'b0;
      lat++;
    end while (rd_ack !== 1'b1 && lat < LIMIT);
    if (rd_ack !== 1'b1) begin
      check("rd_ack_timeout", 32'(rd_ack), 32'd1);
      void'(rd_q.pop_back());
    end
    rd_req = 1'b0;
  endtask

  task automatic apply_vec(input int i);
    int lat;
    if (vec[i].is_rd) do_read(vec[i].restart, vec[i].exp_rdata, vec[i].exp_flag, lat);
    else do_write(vec[i].data, vec[i].exp_flag, lat);
    check($sformatf("v%0d_latency", i), 32'(lat), 32'(vec[i].exp_lat));
    check($sformatf("v%0d_count", i), 32'(count), 32'(vec[i].exp_count));
    check($sformatf("v%0d_full", i), 32'(full), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, nz, lat, lw, lr, n, t, exp_cnt;
    int ack_t [3];

    vec[0] = '{0, 0, 8'h48, 1'b0, 8'h00, 8'd1, 2};
    vec[1] = '{0, 0, 8'h69, 1'b0, 8'h00, 8'd2, 2};
    vec[2] = '{1, 0, 8'h00, 1'b1, 8'h00, 8'd2, 3};
    vec[3] = '{0, 0, 8'h08, 1'b0, 8'h00, BS ? 8'd1 : 8'd3, 2};
    vec[4] = '{1, 0, 8'h00, BS, BS ? 8'h00 : 8'h08, BS ? 8'd1 : 8'd3, 3};
    vec[5] = '{1, 1, 8'h00, 1'b0, 8'h48, BS ? 8'd1 : 8'd3, 3};
    vec[6] = '{0, 0, 8'h78, 1'b0, 8'h00, BS ? 8'd2 : 8'd4, 2};
    vec[7] = '{1, 0, 8'h00, 1'b0, BS ? 8'h78 : 8'h69, BS ? 8'd2 : 8'd4, 3};

    reset = 1'b1; tb_fill = 1'b1;
    clr_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0; rd_restart = 1'b0; wr_data = 8'h00;
    repeat (256) @(negedge sysclk);
    tb_fill = 1'b0;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ram_port", 32'({ram_write, ram_addr, ram_din}), 32'd0);
    check("rst_acks", 32'({wr_ack, wr_drop, rd_ack, rd_end, rd_data}), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);

    // Clear sweep after reset
    reset = 1'b0;
    bad = 0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge sysclk);
      if (!(ram_write === 1'b1 && ram_addr === 8'(k - 1) && ram_din === 16'h0000)) bad++;
      if (k == 255) check("clr_busy_255", 32'(busy), 32'd1);
      if (k == 256) check("clr_busy_256", 32'(busy), 32'd0);
    end
    check("clr_sweep_bad_cycles", 32'(bad), 32'd0);
    @(negedge sysclk);
    check("clr_idle_no_write", 32'(ram_write), 32'd0);
    check("clr_count", 32'(count), 32'd0);
    nz = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== 16'h0000) nz++;
    check("clr_ram_nonzero_words", 32'(nz), 32'd0);

    // Two writes, then held read of three slots
    for (int i = 0; i < 2; i++) apply_vec(i);
    @(negedge sysclk);
    check("ram0_H", 32'(mem[0]), 32'h8048);
    check("ram1_i", 32'(mem[1]), 32'h8069);

    rd_q.push_back({1'b0, 8'h48});
    rd_q.push_back({1'b0, 8'h69});
    rd_q.push_back({1'b1, 8'h00});
    rd_req = 1'b1; n = 0; t = 0;
    while (n < 3 && t < 100) begin
      @(negedge sysclk);
      t++;
      if (rd_ack === 1'b1) begin
        ack_t[n] = t;
        n++;
      end
    end
    rd_req = 1'b0;
    check("held_rd_acks", 32'(n), 32'd3);
    check("held_rd_first_lat", 32'(ack_t[0]), 32'd3);
    check("held_rd_gap1", 32'(ack_t[1] - ack_t[0]), 32'd3);
    check("held_rd_gap2", 32'(ack_t[2] - ack_t[1]), 32'd3);

    for (int i = 2; i < 8; i++) apply_vec(i);
    @(negedge sysclk);
    if (BS) begin
      check("ram1_after_bs", 32'(mem[1]), 32'h8078);
      check("ram2_after_bs", 32'(mem[2]), 32'h0000);
    end else begin
      check("ram1_kept", 32'(mem[1]), 32'h8069);
      check("ram2_bs_char", 32'(mem[2]), 32'h8008);
      check("ram3_x", 32'(mem[3]), 32'h8078);
    end

    // Fill to capacity, then one more write is dropped
    exp_cnt = BS ? 2 : 4;
    for (int c = exp_cnt; c < MAX; c++) begin
      if (c == MAX - 1) check("full_before_last", 32'(full), 32'd0);
      do_write(8'h61 + 8'(c % 26), 1'b0, lat);
    end
    check("fill_count", 32'(count), 32'(MAX));
    check("fill_full", 32'(full), 32'd1);
    do_write(8'h71, 1'b1, lat);
    check("overflow_count", 32'(count), 32'(MAX));
    check("overflow_full", 32'(full), 32'd1);

    // clr_req, wr_req, rd_req together; clr held across a second sweep
    fork
      begin
        clr_req = 1'b1;
        repeat (300) @(negedge sysclk);
        check("clr_held_busy", 32'(busy), 32'd1);
        clr_req = 1'b0;
      end
      do_write(8'h5A, 1'b0, lw);
      do_read(1'b0, 8'h5A, 1'b0, lr);
    join
    check("arb_wr_latency", 32'(lw), 32'd516);
    check("arb_rd_latency", 32'(lr), 32'd519);
    check("arb_count", 32'(count), 32'd1);
    check("arb_full", 32'(full), 32'd0);

    // Reset in WRITE drops the ack and restarts the sweep
    wr_data = 8'h41; wr_req = 1'b1;
    @(negedge sysclk);
    reset = 1'b1; wr_req = 1'b0;
    @(negedge sysclk);
    check("rst_mid_wr_ack", 32'(wr_ack), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd1);
    check("rst_mid_count", 32'(count), 32'd0);
    check("rst_mid_ram_write", 32'(ram_write), 32'd0);
    reset = 1'b0;
    do_write(8'h61, 1'b0, lw);
    check("post_rst_wr_latency", 32'(lw), 32'd258);
    check("post_rst_count", 32'(count), 32'd1);

    // Backspace character handling
`ifdef MSG_BACKSPACE_EN
    do_write(8'h08, 1'b0, lat);
    check("bs_count", 32'(count), 32'd0);
    @(negedge sysclk);
    check("bs_ram0", 32'(mem[0]), 32'h0000);
    do_write(8'h08, 1'b1, lat);
    check("bs_empty_count", 32'(count), 32'd0);
`else
    do_write(8'h08, 1'b0, lat);
    check("bs_char_count", 32'(count), 32'd2);
    @(negedge sysclk);
    check("bs_char_ram1", 32'(mem[1]), 32'h8008);
`endif

    repeat (4) @(negedge sysclk);
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
